// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: video fetch reads have strict priority,
// CPU strobe/ack accesses run in the free slots.
module vram_arbiter #(
    parameter int AW      = 14,
    parameter int RAM_LAT = 1
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [15:0]   vid_data,
    output logic          vid_valid,
    output logic          vid_ovr,
    input  logic          cpu_stb,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [15:0]   cpu_din,
    output logic [15:0]   cpu_dout,
    output logic          cpu_ack,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [1:0]    ram_be,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_dout
);

    // state | meaning
    // IDLE  | RAM free, pick video pending / video request / CPU pending
    // VRD   | video address on the RAM
    // VWT   | waiting RAM_LAT cycles for video data
    // CRD   | CPU read address on the RAM
    // CWT   | waiting RAM_LAT cycles for CPU read data
    // CWR   | CPU write strobe, one cycle
    typedef enum logic [2:0] {IDLE, VRD, VWT, CRD, CWT, CWR} state_t;

    localparam logic [1:0] LAT_LD = 2'(RAM_LAT - 1);

    state_t        state;
    logic [1:0]    lat_cnt;
    logic          old_stb;
    logic          armed;
    logic          vid_pend;
    logic [AW-1:0] vid_pend_addr;
    logic          cpu_pend;
    logic          cpu_busy;
    logic          cpu_drop;
    logic          cpu_we_q;
    logic [1:0]    cpu_be_q;
    logic [AW-1:0] cpu_addr_q;
    logic [15:0]   cpu_din_q;
    logic          cpu_edge;

    // armed masks the first cycle after reset so a strobe already high is not an edge
    assign cpu_edge = cpu_stb && !old_stb && armed && !cpu_busy;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            lat_cnt       <= '0;
            old_stb       <= 1'b0;
            armed         <= 1'b0;
            vid_pend      <= 1'b0;
            vid_pend_addr <= '0;
            cpu_pend      <= 1'b0;
            cpu_busy      <= 1'b0;
            cpu_drop      <= 1'b0;
            cpu_we_q      <= 1'b0;
            cpu_be_q      <= '0;
            cpu_addr_q    <= '0;
            cpu_din_q     <= '0;
            vid_data      <= '0;
            vid_valid     <= 1'b0;
            vid_ovr       <= 1'b0;
            cpu_dout      <= '0;
            cpu_ack       <= 1'b0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_be        <= '0;
            ram_din       <= '0;
        end else begin
            old_stb   <= cpu_stb;
            armed     <= 1'b1;
            vid_valid <= 1'b0;

            if (cpu_edge) begin
                cpu_busy   <= 1'b1;
                cpu_pend   <= 1'b1;
                cpu_drop   <= 1'b0;
                cpu_we_q   <= cpu_we;
                cpu_be_q   <= cpu_be;
                cpu_addr_q <= cpu_addr;
                cpu_din_q  <= cpu_din;
            end else if (cpu_busy && !cpu_stb && !cpu_ack) begin
                cpu_drop <= 1'b1;
            end

            if (cpu_ack && !cpu_stb) begin
                cpu_ack  <= 1'b0;
                cpu_busy <= 1'b0;
            end

            // requests arriving while the RAM is busy go to the 1-deep slot
            if (state != IDLE && vid_req) begin
                if (vid_pend)
                    vid_ovr <= 1'b1;
                vid_pend      <= 1'b1;
                vid_pend_addr <= vid_addr;
            end

            case (state)
                IDLE: begin
                    if (vid_pend) begin
                        ram_addr <= vid_pend_addr;
                        state    <= VRD;
                        vid_pend <= vid_req;
                        if (vid_req)
                            vid_pend_addr <= vid_addr;
                    end else if (vid_req) begin
                        ram_addr <= vid_addr;
                        state    <= VRD;
                    end else if (cpu_pend) begin
                        cpu_pend <= 1'b0;
                        ram_addr <= cpu_addr_q;
                        if (cpu_we_q) begin
                            ram_we  <= 1'b1;
                            ram_be  <= cpu_be_q;
                            ram_din <= cpu_din_q;
                            state   <= CWR;
                        end else begin
                            state <= CRD;
                        end
                    end
                end
                VRD: begin
                    lat_cnt <= LAT_LD;
                    state   <= VWT;
                end
                VWT: begin
                    if (lat_cnt == 2'd0) begin
                        vid_data  <= ram_dout;
                        vid_valid <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                CRD: begin
                    lat_cnt <= LAT_LD;
                    state   <= CWT;
                end
                CWT: begin
                    if (lat_cnt == 2'd0) begin
                        cpu_dout <= ram_dout;
                        state    <= IDLE;
                        if (cpu_stb && !cpu_drop)
                            cpu_ack <= 1'b1;
                        else
                            cpu_busy <= 1'b0;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                CWR: begin
                    ram_we <= 1'b0;
                    state  <= IDLE;
                    if (cpu_stb && !cpu_drop)
                        cpu_ack <= 1'b1;
                    else
                        cpu_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a 16K x 16 synchronous RAM model (1-cycle latency).
module tb_vram_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        vid_req = 1'b0;
    logic [13:0] vid_addr = '0;
    logic [15:0] vid_data;
    logic        vid_valid;
    logic        vid_ovr;
    logic        cpu_stb = 1'b0;
    logic        cpu_we = 1'b0;
    logic [1:0]  cpu_be = '0;
    logic [13:0] cpu_addr = '0;
    logic [15:0] cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        cpu_ack;
    logic [13:0] ram_addr;
    logic        ram_we;
    logic [1:0]  ram_be;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;

    logic [15:0] mem [0:16383];
    logic [15:0] rd_q = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          we_cnt = 0;
    int          we_snap = 0;
    logic        b_seen = 1'b0;

    always #5 clk_sys = ~clk_sys;

    vram_arbiter #(.AW(14), .RAM_LAT(1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vid_ovr(vid_ovr),
        .cpu_stb(cpu_stb), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    assign ram_dout = rd_q;

    always @(posedge clk_sys) begin
        rd_q <= mem[ram_addr];
        if (ram_we) begin
            if (ram_be[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
            if (ram_be[1]) mem[ram_addr][15:8] <= ram_din[15:8];
        end
    end

    always @(negedge clk_sys) begin
        if (ram_we) we_cnt++;
        if (ram_addr == 14'h0700) b_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
        mem[14'h1234] = 16'hA5C3;
        mem[14'h0010] = 16'h1122;
        mem[14'h0200] = 16'hBEEF;
        mem[14'h0300] = 16'hCAFE;
        mem[14'h0400] = 16'h1357;
        mem[14'h0500] = 16'h2468;
        mem[14'h0600] = 16'h1111;
        mem[14'h0700] = 16'h2222;
        mem[14'h0800] = 16'h3333;

        // reset state
        #12;
        chk("rst_vid_data", 32'(vid_data), 32'h0);
        chk("rst_vid_valid", 32'(vid_valid), 32'h0);
        chk("rst_cpu_ack", 32'(cpu_ack), 32'h0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h0);
        chk("rst_ram_we", 32'(ram_we), 32'h0);
        reset_n = 1'b1;
        step(); step();

        // isolated video read
        step(); vid_req = 1'b1; vid_addr = 14'h1234;
        step(); vid_req = 1'b0;
        chk("vid_ram_addr_T1", 32'(ram_addr), 32'h1234);
        chk("vid_valid_T1", 32'(vid_valid), 32'h0);
        step();
        chk("vid_valid_T2", 32'(vid_valid), 32'h0);
        step();
        chk("vid_valid_T3", 32'(vid_valid), 32'h1);
        chk("vid_data_T3", 32'(vid_data), 32'hA5C3);
        chk("vid_ovr_iso", 32'(vid_ovr), 32'h0);
        step();
        chk("vid_valid_T4", 32'(vid_valid), 32'h0);

        // CPU byte write
        we_snap = we_cnt;
        step(); cpu_stb = 1'b1; cpu_we = 1'b1; cpu_be = 2'b01; cpu_addr = 14'h0010; cpu_din = 16'hFF77;
        step();
        chk("wr_we_T1", 32'(ram_we), 32'h0);
        step();
        chk("wr_we_T2", 32'(ram_we), 32'h1);
        chk("wr_be_T2", 32'(ram_be), 32'h1);
        chk("wr_din_T2", 32'(ram_din), 32'hFF77);
        step();
        chk("wr_ack_T3", 32'(cpu_ack), 32'h1);
        chk("wr_we_T3", 32'(ram_we), 32'h0);
        cpu_stb = 1'b0;
        step();
        chk("wr_ack_clr", 32'(cpu_ack), 32'h0);
        chk("wr_mem", 32'(mem[14'h0010]), 32'h1177);
        chk("wr_pulses", 32'(we_cnt - we_snap), 32'h1);

        // CPU read back
        step(); cpu_stb = 1'b1; cpu_we = 1'b0; cpu_be = 2'b00;
        step();
        step();
        chk("rd_addr_T2", 32'(ram_addr), 32'h0010);
        step();
        chk("rd_ack_T3", 32'(cpu_ack), 32'h0);
        step();
        chk("rd_ack_T4", 32'(cpu_ack), 32'h1);
        chk("rd_dout_T4", 32'(cpu_dout), 32'h1177);
        step();
        chk("rd_ack_hold", 32'(cpu_ack), 32'h1);
        cpu_stb = 1'b0;
        step();
        chk("rd_ack_clr", 32'(cpu_ack), 32'h0);

        // collision: video first, CPU read right after
        step(); vid_req = 1'b1; vid_addr = 14'h0200; cpu_stb = 1'b1; cpu_addr = 14'h0300;
        step(); vid_req = 1'b0;
        step();
        step();
        chk("col_vid_valid_T3", 32'(vid_valid), 32'h1);
        chk("col_vid_data_T3", 32'(vid_data), 32'hBEEF);
        step();
        chk("col_ram_addr_T4", 32'(ram_addr), 32'h0300);
        step();
        chk("col_ack_T5", 32'(cpu_ack), 32'h0);
        step();
        chk("col_ack_T6", 32'(cpu_ack), 32'h1);
        chk("col_dout_T6", 32'(cpu_dout), 32'hCAFE);
        cpu_stb = 1'b0;
        step();

        // video request during CPU read
        step(); cpu_stb = 1'b1; cpu_addr = 14'h0400;
        step();
        step();
        chk("vdc_cpu_addr", 32'(ram_addr), 32'h0400);
        step(); vid_req = 1'b1; vid_addr = 14'h0500;
        step(); vid_req = 1'b0;
        chk("vdc_ack", 32'(cpu_ack), 32'h1);
        chk("vdc_dout", 32'(cpu_dout), 32'h1357);
        step();
        chk("vdc_vid_addr", 32'(ram_addr), 32'h0500);
        step();
        chk("vdc_valid_R3", 32'(vid_valid), 32'h0);
        step();
        chk("vdc_valid_R4", 32'(vid_valid), 32'h1);
        chk("vdc_data", 32'(vid_data), 32'h2468);
        cpu_stb = 1'b0;
        step(); step();

        // overrun: A served, B overwritten, C served
        step(); vid_req = 1'b1; vid_addr = 14'h0600;
        step(); vid_addr = 14'h0700;
        step(); vid_addr = 14'h0800;
        chk("ovr_before", 32'(vid_ovr), 32'h0);
        step(); vid_req = 1'b0;
        chk("ovr_A_valid", 32'(vid_valid), 32'h1);
        chk("ovr_A_data", 32'(vid_data), 32'h1111);
        chk("ovr_set", 32'(vid_ovr), 32'h1);
        step();
        chk("ovr_C_addr", 32'(ram_addr), 32'h0800);
        step();
        step();
        chk("ovr_C_valid", 32'(vid_valid), 32'h1);
        chk("ovr_C_data", 32'(vid_data), 32'h3333);
        step(); step(); step();
        chk("ovr_B_never", 32'(b_seen), 32'h0);
        chk("ovr_sticky", 32'(vid_ovr), 32'h1);

        // reset during CWR
        step(); cpu_stb = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 14'h0900; cpu_din = 16'h5A5A;
        step();
        step();
        chk("rmo_in_cwr", 32'(ram_we), 32'h1);
        we_snap = we_cnt;
        #2 reset_n = 1'b0;
        #1;
        chk("rmo_we_drop", 32'(ram_we), 32'h0);
        chk("rmo_ram_addr", 32'(ram_addr), 32'h0);
        chk("rmo_ovr_clr", 32'(vid_ovr), 32'h0);
        chk("rmo_vid_data", 32'(vid_data), 32'h0);
        chk("rmo_ack", 32'(cpu_ack), 32'h0);
        #3 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("rmo_held_stb_no_we", 32'(we_cnt - we_snap), 32'h0);
        chk("rmo_held_stb_no_ack", 32'(cpu_ack), 32'h0);
        chk("rmo_not_written", 32'(mem[14'h0900]), 32'h0);
        cpu_stb = 1'b0;
        step();
        step(); cpu_stb = 1'b1;
        step(); step(); step();
        chk("rmo_fresh_ack", 32'(cpu_ack), 32'h1);
        chk("rmo_fresh_mem", 32'(mem[14'h0900]), 32'h5A5A);
        chk("rmo_fresh_we", 32'(we_cnt - we_snap), 32'h1);
        cpu_stb = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Single-port arbiter in front of the 16K x 16 video RAM.
- Serves two requesters:
  - the video fetch stage, which issues one word read per 16-pixel group;
  - the CPU bus, which issues byte/word reads and writes to screen memory.
- Video reads have strict priority and fixed latency when the RAM is idle.
- CPU accesses use a strobe/ack handshake and run in the free RAM slots.

Parameters:
- AW, 14: word address width (bank bit + 13 bits).
- RAM_LAT, 1: clocks from ram_addr being sampled by RAM to ram_dout valid (1..3).

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  one-cycle read request from the video fetch stage.
- vid_addr  in  AW  video read address, valid when vid_req=1.
- vid_data  out  16  last video word read; held until the next video read completes.
- vid_valid  out  1  one-cycle pulse; vid_data updated this cycle.
- vid_ovr  out  1  sticky flag: video request overrun.
- cpu_stb  in  1  CPU access strobe; a rising edge starts an access.
- cpu_we  in  1  1=write, 0=read.
- cpu_be  in  2  byte enables: [0] low byte, [1] high byte.
- cpu_addr  in  AW  CPU word address.
- cpu_din  in  16  CPU write data.
- cpu_dout  out  16  CPU read data; valid while cpu_ack=1.
- cpu_ack  out  1  access done; held until cpu_stb falls.
- ram_addr  out  AW  RAM address (registered).
- ram_we  out  1  RAM write enable (registered, one-cycle pulse).
- ram_be  out  2  RAM byte enables (registered).
- ram_din  out  16  RAM write data (registered).
- ram_dout  in  16  RAM read data.

Behaviour:
- Reset:
  - Async assert of reset_n=0 clears all outputs to 0 and state to IDLE.
  - Clears the video pending slot, the CPU pending slot, the old_stb register and vid_ovr.
  - Reset mid-access aborts the access; ram_we drops immediately.
  - After release, the first cpu_stb edge is detected normally; a stb already high at release does not start an access.
- FSM states:
  - IDLE.
  - VRD: video address on the RAM.
  - VWT: waiting RAM_LAT cycles.
  - CRD: CPU read address on the RAM.
  - CWT: waiting RAM_LAT cycles.
  - CWR: CPU write, one cycle.
- Video path:
  - vid_req=1 in cycle T while in IDLE (or pending at IDLE): the next state is VRD and ram_addr<=vid_addr.
  - The RAM samples at the end of T+1. The FSM stays in VWT until ram_dout is valid, then vid_data<=ram_dout.
  - vid_valid is high in cycle T+2+RAM_LAT (T+3 at default).
  - vid_req arriving in a non-IDLE state is stored in a 1-deep video pending slot and served at the next IDLE, before any CPU request.
  - Worst-case video latency: 2+RAM_LAT + remaining CPU-op cycles (at most 1+RAM_LAT).
  - A second vid_req while the slot is already full overwrites the pending address with the newest one and sets vid_ovr=1. vid_ovr clears only on reset.
  - vid_req arriving in the same cycle a pending video read starts is stored, not dropped.
- CPU path:
  - Rising edge = cpu_stb=1 and old_stb=0, with old_stb registered each clock.
  - On the edge, addr/we/be/din are latched into the CPU pending slot.
  - The CPU request starts only from IDLE, and only if there is no vid_req this cycle and no video pending.
  - Write: CWR drives ram_we=1, ram_be=cpu_be and ram_din=cpu_din for exactly 1 cycle, then back to IDLE.
    - cpu_be=00 still takes the slot but writes nothing (ram_we=1, ram_be=00).
  - Read: CRD then CWT; when data is valid, cpu_dout<=ram_dout (full word regardless of be).
  - cpu_ack rises the cycle after the op completes if cpu_stb is still 1. It stays high while cpu_stb=1 and clears the cycle after cpu_stb=0.
  - cpu_stb falling before completion: a latched op still completes (writes are committed), but ack is never raised.
  - A new stb edge while an op is latched is ignored until ack or abandonment clears the slot.
- ram_we is 0 in every state except CWR. ram_addr holds its last value in IDLE.
- Simultaneous vid_req and cpu_stb edge in IDLE: video goes first; the CPU op starts right after video returns to IDLE.

Test Plan:
- Isolated video read:
  - Stimulus: RAM[0x1234]=0xA5C3, vid_req with vid_addr=0x1234 at T.
  - Required: ram_addr=0x1234 at T+1; vid_valid pulse at T+3 with vid_data=0xA5C3; vid_ovr=0.
- CPU byte write then read:
  - Stimulus: stb edge with we=1, be=01, addr=0x0010, din=0xFF77 on a RAM word preloaded with 0x1122.
  - Required: one ram_we pulse with be=01; then ack.
  - Follow-up read returns 0x1177 with cpu_ack held until stb drops, then cleared next cycle.
- Collision:
  - Stimulus: vid_req and CPU read edge in the same cycle T.
  - Required: video vid_valid at T+3; CPU ram_addr driven at T+4; cpu_ack at T+6.
- Video during CPU read:
  - Stimulus: vid_req one cycle after a CPU read starts.
  - Required: video is served immediately after CWT; vid_valid no later than 2+RAM_LAT+(1+RAM_LAT) cycles after the request; data correct.
- Overrun:
  - Stimulus: three vid_req pulses on back-to-back cycles with addrs A, B, C.
  - Required: A served, C served, B never read; vid_ovr=1 and stays 1 until reset_n pulse.
- Reset mid-op:
  - Stimulus: assert reset_n=0 during CWR.
  - Required: ram_we=0 immediately; all outputs 0.
  - After release, stb held high produces no access; the next fresh edge works.
